// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-memory loader.
// The master drives bytes and the slave (loader) signals readiness.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed, checksummed byte stream
// in, one instruction word written per data byte, CPU held until a clean load.
module imem_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      stream,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W:0]     remaining_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          sum_r;
    logic                in_ready_r;
    logic                in_ready_nxt_s;
    logic                cpu_hold_r;
    logic                cpu_hold_nxt_s;
    logic                load_done_r;
    logic                load_done_nxt_s;
    logic                load_err_r;
    logic                load_err_nxt_s;
    logic                imem_we_r;
    logic [ADDR_W-1:0]   imem_waddr_r;
    logic [7:0]          imem_wdata_r;
    logic                xfer_s;

    // A length byte of zero stands for a full 2^ADDR_W-word program.
    function automatic logic [ADDR_W:0] decode_len(input logic [7:0] len_byte);
        logic [ADDR_W:0] len_v;
        if (len_byte == 8'd0) begin
            len_v = {1'b1, {ADDR_W{1'b0}}};
        end else begin
            len_v = (ADDR_W+1)'(len_byte);
        end
        return len_v;
    endfunction

    assign xfer_s          = stream.in_valid && in_ready_r;
    assign stream.in_ready = in_ready_r;
    assign imem_we         = imem_we_r;
    assign imem_waddr      = imem_waddr_r;
    assign imem_wdata      = imem_wdata_r;
    assign cpu_hold        = cpu_hold_r;
    assign load_done       = load_done_r;
    assign load_err        = load_err_r;

    // Next-state decode plus the state-only status flags for the coming cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nxt_s = ST_LEN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LEN: begin
                if (xfer_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_LEN;
                end
            end
            ST_DATA: begin
                if (xfer_s && (remaining_r == (ADDR_W+1)'(1'b1))) begin
                    state_nxt_s = ST_CSUM;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (xfer_s) begin
                    state_nxt_s = (stream.in_data == sum_r) ? ST_DONE : ST_ERR;
                end else begin
                    state_nxt_s = ST_CSUM;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        in_ready_nxt_s  = (state_nxt_s == ST_LEN) || (state_nxt_s == ST_DATA) ||
                          (state_nxt_s == ST_CSUM);
        cpu_hold_nxt_s  = (state_nxt_s != ST_DONE);
        load_done_nxt_s = (state_nxt_s == ST_DONE);
        load_err_nxt_s  = (state_nxt_s == ST_ERR);
    end

    // State register and registered status outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            cpu_hold_r  <= 1'b1;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            cpu_hold_r  <= cpu_hold_nxt_s;
            load_done_r <= load_done_nxt_s;
            load_err_r  <= load_err_nxt_s;
        end
    end

    // Load datapath: length capture, address/checksum tracking, write strobe.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            imem_we_r    <= 1'b0;
            imem_waddr_r <= BASE_ADDR;
            imem_wdata_r <= 8'h00;
            remaining_r  <= {(ADDR_W+1){1'b0}};
            addr_r       <= BASE_ADDR;
            sum_r        <= 8'h00;
        end else begin
            imem_we_r <= 1'b0;
            if (xfer_s) begin
                case (state_r)
                    ST_LEN: begin
                        remaining_r <= decode_len(stream.in_data);
                        addr_r      <= BASE_ADDR;
                        sum_r       <= 8'h00;
                    end
                    ST_DATA: begin
                        imem_we_r    <= 1'b1;
                        imem_waddr_r <= addr_r;
                        imem_wdata_r <= stream.in_data;
                        addr_r       <= addr_r + ADDR_W'(1'b1);
                        sum_r        <= sum_r + stream.in_data;
                        remaining_r  <= remaining_r - (ADDR_W+1)'(1'b1);
                    end
                    default: begin
                        remaining_r <= remaining_r;
                    end
                endcase
            end else begin
                remaining_r <= remaining_r;
            end
        end
    end

endmodule
